// File: rtl/excp_pkg.sv
// excp_pkg: exception codes, FSM states and default vectors
// shared by the exception unit and its priority encoder.
package excp_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_IBE = 5'd6;
  localparam logic [4:0] EXC_DBE = 5'd7;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_CPU = 5'd11;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [31:0] DEF_RESET_VEC = 32'hBFC0_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'hBFC0_0180;
  localparam int DEF_RESET_HOLD = 4;
  localparam int DEF_FLUSH_LEN  = 3;

  typedef enum logic [1:0] {
    S_RST,
    S_RUN,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/excp_prio_enc.sv
// excp_prio_enc: maps WB fault flags to {taken, ExcCode}
// using fixed priority, highest first.
module excp_prio_enc
  import excp_pkg::*;
(
  input  logic       ibe,
  input  logic       cpu,
  input  logic       ri,
  input  logic       sys,
  input  logic       brk,
  input  logic       ov,
  input  logic       dbe,
  input  logic       intr,
  output logic       taken,
  output logic [4:0] code
);

  // First matching flag wins
  always_comb begin
    taken = 1'b1;
    code  = EXC_INT;
    priority case (1'b1)
      ibe:  code = EXC_IBE;
      cpu:  code = EXC_CPU;
      ri:   code = EXC_RI;
      sys:  code = EXC_SYS;
      brk:  code = EXC_BP;
      ov:   code = EXC_OV;
      dbe:  code = EXC_DBE;
      intr: code = EXC_INT;
      default: begin
        taken = 1'b0;
        code  = EXC_INT;
      end
    endcase
  end

endmodule

// File: rtl/exception_unit.sv
// exception_unit: exception/ERET decision, reset hold and flush window.
// Optional EXCP_STATS_EN adds a saturating exception counter.
module exception_unit
  import excp_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC = DEF_EXC_VEC,
  parameter int RESET_HOLD = DEF_RESET_HOLD,
  parameter int FLUSH_LEN = DEF_FLUSH_LEN
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        IEN_WB,
  input  logic        ERET,
  input  logic        SYSCALL,
  input  logic        BREAK,
  input  logic        RI,
  input  logic        CpU,
  input  logic        OV,
  input  logic        IBE,
  input  logic        DBE,
  input  logic        INT_COUNTER,
  input  logic [31:0] PC_WB,
  input  logic        DELAY_SLOT,
  input  logic [31:0] EPC_Q,
  input  logic        INST_SUBST,
  output logic        RESET,
  output logic        E_ENTER,
  output logic        E_USE_VEC,
  output logic [31:0] VECTOR,
  output logic [31:0] EPC,
`ifdef EXCP_STATS_EN
  input  logic        EXC_COUNT_CLR,
  output logic [15:0] EXC_COUNT,
`endif
  output logic [4:0]  CAUSE
);

  localparam logic [3:0] RCNT_LAST = 4'(RESET_HOLD - 1);
  localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_LEN - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] rcnt;
  logic [3:0] rcnt_nx;
  logic [2:0] fcnt;
  logic [2:0] fcnt_nx;

  logic       eval;
  logic       f_taken;
  logic [4:0] f_code;
  logic       take;
  logic       eret_go;

  excp_prio_enc u_enc (
    .ibe   (IBE),
    .cpu   (CpU),
    .ri    (RI),
    .sys   (SYSCALL),
    .brk   (BREAK),
    .ov    (OV),
    .dbe   (DBE),
    .intr  (INT_COUNTER),
    .taken (f_taken),
    .code  (f_code)
  );

  assign eval    = (state == S_RUN) && IEN_WB && !INST_SUBST;
  assign take    = eval && f_taken;
  assign eret_go = eval && ERET && !f_taken;

  // State and counter registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_RST;
      rcnt  <= 4'd0;
      fcnt  <= 3'd0;
    end else begin
      state <= state_nx;
      rcnt  <= rcnt_nx;
      fcnt  <= fcnt_nx;
    end
  end

  // Next state: hold count, redirect decision, flush countdown
  always_comb begin
    state_nx = state;
    rcnt_nx  = rcnt;
    fcnt_nx  = fcnt;
    case (state)
      S_RST: begin
        rcnt_nx = rcnt + 4'd1;
        if (rcnt == RCNT_LAST) begin
          state_nx = S_RUN;
          rcnt_nx  = 4'd0;
        end
      end
      S_RUN: begin
        if (take || eret_go) begin
          state_nx = S_FLUSH;
          fcnt_nx  = FCNT_LOAD;
        end
      end
      S_FLUSH: begin
        if (fcnt == 3'd0) begin
          state_nx = S_RUN;
        end else begin
          fcnt_nx = fcnt - 3'd1;
        end
      end
      default: begin
        state_nx = S_RST;
        rcnt_nx  = 4'd0;
        fcnt_nx  = 3'd0;
      end
    endcase
  end

  // Outputs toward CP0 and fetch
  always_comb begin
    RESET     = 1'b0;
    E_ENTER   = 1'b0;
    E_USE_VEC = 1'b0;
    VECTOR    = EXC_VEC;
    CAUSE     = 5'd0;
    EPC       = PC_WB;
    case (state)
      S_RUN: begin
        if (take) begin
          E_ENTER   = 1'b1;
          E_USE_VEC = 1'b1;
          CAUSE     = f_code;
          EPC       = DELAY_SLOT ? PC_WB - 32'd4 : PC_WB;
        end else if (eret_go) begin
          E_USE_VEC = 1'b1;
          VECTOR    = EPC_Q;
        end
      end
      S_FLUSH: begin
        E_USE_VEC = 1'b0;
      end
      default: begin
        RESET     = 1'b1;
        E_USE_VEC = 1'b1;
        VECTOR    = RESET_VEC;
        EPC       = 32'd0;
      end
    endcase
  end

`ifdef EXCP_STATS_EN
  // Saturating entry counter, clear beats increment
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      EXC_COUNT <= 16'd0;
    end else if (EXC_COUNT_CLR) begin
      EXC_COUNT <= 16'd0;
    end else if (E_ENTER && EXC_COUNT != 16'hFFFF) begin
      EXC_COUNT <= EXC_COUNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: directed checks of reset hold, entry, ERET,
// priority, flush window and async reset of exception_unit.
module tb_exception_unit;

  logic        CLK;
  logic        RESET_N;
  logic        IEN_WB;
  logic        ERET;
  logic        SYSCALL;
  logic        BREAK;
  logic        RI;
  logic        CpU;
  logic        OV;
  logic        IBE;
  logic        DBE;
  logic        INT_COUNTER;
  logic [31:0] PC_WB;
  logic        DELAY_SLOT;
  logic [31:0] EPC_Q;
  logic        INST_SUBST;
  logic        RESET;
  logic        E_ENTER;
  logic        E_USE_VEC;
  logic [31:0] VECTOR;
  logic [31:0] EPC;
  logic [4:0]  CAUSE;
`ifdef EXCP_STATS_EN
  logic        EXC_COUNT_CLR;
  logic [15:0] EXC_COUNT;
`endif

  int checks = 0;
  int errors = 0;

  exception_unit dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .IEN_WB      (IEN_WB),
    .ERET        (ERET),
    .SYSCALL     (SYSCALL),
    .BREAK       (BREAK),
    .RI          (RI),
    .CpU         (CpU),
    .OV          (OV),
    .IBE         (IBE),
    .DBE         (DBE),
    .INT_COUNTER (INT_COUNTER),
    .PC_WB       (PC_WB),
    .DELAY_SLOT  (DELAY_SLOT),
    .EPC_Q       (EPC_Q),
    .INST_SUBST  (INST_SUBST),
    .RESET       (RESET),
    .E_ENTER     (E_ENTER),
    .E_USE_VEC   (E_USE_VEC),
    .VECTOR      (VECTOR),
    .EPC         (EPC),
`ifdef EXCP_STATS_EN
    .EXC_COUNT_CLR (EXC_COUNT_CLR),
    .EXC_COUNT     (EXC_COUNT),
`endif
    .CAUSE       (CAUSE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic nc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    IEN_WB = 1'b0; ERET = 1'b0; SYSCALL = 1'b0; BREAK = 1'b0;
    RI = 1'b0; CpU = 1'b0; OV = 1'b0; IBE = 1'b0; DBE = 1'b0;
    INT_COUNTER = 1'b0; PC_WB = 32'h0; DELAY_SLOT = 1'b0;
    EPC_Q = 32'h0; INST_SUBST = 1'b0;
  endtask

  // step past the 3-cycle flush window with idle inputs
  task automatic flush3();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      nc();
      settle();
      chk("flush_usevec", 32'(E_USE_VEC), 32'd0);
    end
    nc();
  endtask

  task automatic fault_chk(input string tag, input logic [4:0] exp);
    IEN_WB = 1'b1;
    settle();
    chk({tag, "_enter"}, 32'(E_ENTER), 32'd1);
    chk({tag, "_cause"}, 32'(CAUSE), 32'(exp));
    flush3();
  endtask

  initial begin
    idle_in();
`ifdef EXCP_STATS_EN
    EXC_COUNT_CLR = 1'b0;
`endif
    RESET_N = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    settle();
    chk("rst_reset", 32'(RESET), 32'd1);
    chk("rst_usevec", 32'(E_USE_VEC), 32'd1);
    chk("rst_vector", VECTOR, 32'hBFC0_0000);
    chk("rst_enter", 32'(E_ENTER), 32'd0);
    chk("rst_epc", EPC, 32'd0);
    chk("rst_cause", 32'(CAUSE), 32'd0);

    // release; faults presented during hold must be ignored
    RESET_N = 1'b1;
    IEN_WB = 1'b1; SYSCALL = 1'b1; INT_COUNTER = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("hold_reset", 32'(RESET), 32'd1);
      chk("hold_vector", VECTOR, 32'hBFC0_0000);
      chk("hold_enter", 32'(E_ENTER), 32'd0);
      nc();
    end
    idle_in();
    settle();
    chk("run_reset", 32'(RESET), 32'd0);
    chk("run_usevec", 32'(E_USE_VEC), 32'd0);
    nc();

    // SYSCALL, held through the flush window
    IEN_WB = 1'b1; SYSCALL = 1'b1; PC_WB = 32'h8000_0100;
    settle();
    chk("sys_enter", 32'(E_ENTER), 32'd1);
    chk("sys_cause", 32'(CAUSE), 32'd8);
    chk("sys_epc", EPC, 32'h8000_0100);
    chk("sys_vector", VECTOR, 32'hBFC0_0180);
    chk("sys_usevec", 32'(E_USE_VEC), 32'd1);
    for (int i = 0; i < 3; i++) begin
      nc();
      settle();
      chk("sys_fl_usevec", 32'(E_USE_VEC), 32'd0);
      chk("sys_fl_enter", 32'(E_ENTER), 32'd0);
    end
    nc();
    idle_in();
    IEN_WB = 1'b1; PC_WB = 32'h8000_0104;
    settle();
    chk("back_usevec", 32'(E_USE_VEC), 32'd0);
    chk("back_epc", EPC, 32'h8000_0104);
    nc();

    // overflow in delay slot, then PC wraparound
    OV = 1'b1; DELAY_SLOT = 1'b1; PC_WB = 32'h8000_0204;
    IEN_WB = 1'b1;
    settle();
    chk("ov_cause", 32'(CAUSE), 32'd12);
    chk("ov_epc", EPC, 32'h8000_0200);
    flush3();
    OV = 1'b1; DELAY_SLOT = 1'b1; PC_WB = 32'h0; IEN_WB = 1'b1;
    settle();
    chk("ovw_epc", EPC, 32'hFFFF_FFFC);
    flush3();

    // priority cases
    IBE = 1'b1; RI = 1'b1; ERET = 1'b1;
    fault_chk("ibe_ri_eret", 5'd6);
    CpU = 1'b1; RI = 1'b1; SYSCALL = 1'b1;
    fault_chk("cpu_ri", 5'd11);
    SYSCALL = 1'b1; BREAK = 1'b1;
    fault_chk("sys_brk", 5'd8);
    BREAK = 1'b1; OV = 1'b1; DBE = 1'b1;
    fault_chk("brk_ov", 5'd9);
    DBE = 1'b1; INT_COUNTER = 1'b1; ERET = 1'b1;
    fault_chk("dbe_int", 5'd7);

    // ERET alone
    ERET = 1'b1; EPC_Q = 32'h8000_0040; IEN_WB = 1'b1;
    settle();
    chk("eret_usevec", 32'(E_USE_VEC), 32'd1);
    chk("eret_vector", VECTOR, 32'h8000_0040);
    chk("eret_enter", 32'(E_ENTER), 32'd0);
    nc();
    settle();
    chk("eret_fl_usevec", 32'(E_USE_VEC), 32'd0);
    nc();
    nc();
    idle_in();
    nc();

    // interrupt gating by INST_SUBST and IEN_WB
    INT_COUNTER = 1'b1; IEN_WB = 1'b1; INST_SUBST = 1'b1;
    settle();
    chk("int_subst", 32'(E_ENTER), 32'd0);
    nc();
    INST_SUBST = 1'b0; IEN_WB = 1'b0;
    settle();
    chk("int_noien", 32'(E_ENTER), 32'd0);
    nc();
    IEN_WB = 1'b1;
    settle();
    chk("int_enter", 32'(E_ENTER), 32'd1);
    chk("int_cause", 32'(CAUSE), 32'd0);
    nc();
    settle();
    chk("int_noback2back", 32'(E_ENTER), 32'd0);
    nc();
    nc();
    idle_in();
    nc();

    // async reset in the middle of a flush
    IEN_WB = 1'b1; SYSCALL = 1'b1; PC_WB = 32'h8000_0300;
    nc();
    idle_in();
    settle();
    chk("mid_pre_usevec", 32'(E_USE_VEC), 32'd0);
    RESET_N = 1'b0;
    #1;
    chk("mid_reset", 32'(RESET), 32'd1);
    chk("mid_vector", VECTOR, 32'hBFC0_0000);
    chk("mid_usevec", 32'(E_USE_VEC), 32'd1);
    nc();
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rehold_reset", 32'(RESET), 32'd1);
      nc();
    end
    settle();
    chk("rerun_reset", 32'(RESET), 32'd0);
    nc();

`ifdef EXCP_STATS_EN
    chk("cnt_reset", 32'(EXC_COUNT), 32'd0);
    for (int i = 0; i < 3; i++) begin
      BREAK = 1'b1;
      fault_chk("cnt_brk", 5'd9);
    end
    settle();
    chk("cnt_three", 32'(EXC_COUNT), 32'd3);
    BREAK = 1'b1; IEN_WB = 1'b1; EXC_COUNT_CLR = 1'b1;
    settle();
    chk("cnt_clr_enter", 32'(E_ENTER), 32'd1);
    nc();
    EXC_COUNT_CLR = 1'b0;
    idle_in();
    settle();
    chk("cnt_clr_wins", 32'(EXC_COUNT), 32'd0);
    nc();
    nc();
    nc();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Consumes the per-instruction fault flags the datapath reports at writeback, plus the CP0 counter interrupt and the saved EPC.
- Decides exception entry or ERET, computes CAUSE and EPC for CP0, and steers instruction fetch to the right vector.
- Sequences the post-reset hold and the flush window after every redirect.
- Sits between datapath/CP0 and the fetch stage.

Parameters:
- RESET_VEC, 32'hBFC0_0000, fetch address after reset.
- EXC_VEC, 32'hBFC0_0180, general exception vector.
- RESET_HOLD, 4, cycles RESET stays high after RESET_N deasserts (1..15).
- FLUSH_LEN, 3, cycles of redirect/blanking after entry or ERET (1..7).

Ports:
- CLK  in  1  CPU clock.
- RESET_N  in  1  asynchronous, active-low reset.
- IEN_WB  in  1  valid architectural instruction in WB.
- ERET, SYSCALL, BREAK, RI, CpU, OV, IBE, DBE  in  1 each  WB fault/return flags.
- INT_COUNTER  in  1  level interrupt request from CP0.
- PC_WB  in  32  PC of the WB instruction.
- DELAY_SLOT  in  1  WB instruction is in a branch delay slot.
- EPC_Q  in  32  EPC currently held in CP0.
- INST_SUBST  in  1  debug instruction substitution active.
- RESET  out  1  synchronous reset for the pipeline.
- E_ENTER  out  1  one-cycle strobe: CP0 latches EPC/CAUSE/BD.
- E_USE_VEC  out  1  fetch takes VECTOR instead of PC+4.
- VECTOR  out  32  redirect target.
- EPC  out  32  exception PC for CP0.
- CAUSE  out  5  ExcCode for CP0.

Behaviour:
- States: S_RST, S_RUN, S_FLUSH. Flush counter fcnt is 3 bits; reset-hold counter rcnt is 4 bits.
- RESET_N low (async): state=S_RST, rcnt=0, fcnt=0, RESET=1, E_USE_VEC=1, VECTOR=RESET_VEC, E_ENTER=0, EPC=0, CAUSE=0.
- S_RST:
  - rcnt increments each cycle.
  - When rcnt==RESET_HOLD-1, go to S_RUN on the next edge.
  - RESET and E_USE_VEC stay high through the last S_RST cycle.
  - All fault inputs are ignored.
- S_RUN, evaluation:
  - Evaluated only when IEN_WB=1 and INST_SUBST=0; otherwise no action.
  - Priority, highest first: IBE(6) > CpU(11) > RI(10) > SYSCALL(8) > BREAK(9) > OV(12) > DBE(7) > INT_COUNTER(0) > ERET.
- S_RUN, exception taken:
  - Combinationally in the same cycle: E_ENTER=1, E_USE_VEC=1, VECTOR=EXC_VEC, CAUSE=code.
  - EPC = DELAY_SLOT ? PC_WB-32'd4 : PC_WB, modulo-2^32 (PC_WB=0 wraps to FFFF_FFFC).
  - Next state S_FLUSH, fcnt=FLUSH_LEN-1.
- S_RUN, ERET (no higher-priority condition): E_ENTER=0, E_USE_VEC=1, VECTOR=EPC_Q, then S_FLUSH.
- S_RUN, nothing taken: E_USE_VEC=0, E_ENTER=0, VECTOR=EXC_VEC, CAUSE=0, EPC=PC_WB (don't-care for CP0).
- S_FLUSH:
  - E_USE_VEC=0, E_ENTER=0; all inputs ignored (squashed instructions).
  - fcnt decrements; at 0, return to S_RUN.
  - FLUSH_LEN=1 returns to S_RUN after one S_FLUSH cycle.
- Simultaneous ERET and any fault: the fault wins, CAUSE per priority.
- INT_COUNTER held high: taken at most once per S_RUN entry with a valid instruction; CP0 clears the request.
- RESET_N asserted mid-flush or mid-hold: immediate async return to S_RST; counters cleared.
- E_ENTER is never high two consecutive cycles.

Optional Feature:
- Macro: EXCP_STATS_EN.
- Defined:
  - Adds output EXC_COUNT[15:0] and input EXC_COUNT_CLR.
  - EXC_COUNT increments on each E_ENTER and saturates at 16'hFFFF.
  - EXC_COUNT_CLR synchronously zeroes it; clear wins over a same-cycle increment.
  - Reset value 0.
- Undefined: neither port exists; behaviour otherwise identical.

Decomposition:
- Package excp_pkg holds:
  - ExcCode localparams: EXC_INT=0, EXC_IBE=6, EXC_DBE=7, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_CPU=11, EXC_OV=12.
  - typedef enum logic[1:0] state_t {S_RST, S_RUN, S_FLUSH}.
  - Default vector constants.
- One sub-module is natural: excp_prio_enc, purely combinational. It maps the fault flags to {taken, code[4:0]}.
- The FSM and counters stay in exception_unit.

Test Plan:
- Reset: RESET_N low 2 cycles, then high; RESET_HOLD=4 -> RESET=1 and VECTOR=BFC0_0000 for exactly 4 cycles after release, then RESET=0, E_USE_VEC=0.
- SYSCALL with IEN_WB=1, PC_WB=8000_0100, DELAY_SLOT=0 -> same cycle E_ENTER=1, CAUSE=8, EPC=8000_0100, VECTOR=BFC0_0180. Next 3 cycles E_USE_VEC=0 and a SYSCALL is ignored.
- OV with DELAY_SLOT=1, PC_WB=8000_0204 -> CAUSE=12, EPC=8000_0200. Repeat with PC_WB=0 -> EPC=FFFF_FFFC.
- IBE+RI+ERET together -> CAUSE=6, E_ENTER=1. ERET alone with EPC_Q=8000_0040 -> E_USE_VEC=1, VECTOR=8000_0040, E_ENTER=0.
- INT_COUNTER=1 with INST_SUBST=1 or IEN_WB=0 -> no entry. Drop INST_SUBST -> E_ENTER=1, CAUSE=0.
- RESET_N pulsed low during S_FLUSH -> immediate RESET=1, VECTOR=BFC0_0000. With EXCP_STATS_EN: 3 entries -> EXC_COUNT=3; CLR with a same-cycle entry -> 0.
